lfsr_byte_packer: RTL and testbench
===================================

# lfsr_byte_packer

Downstream consumer of the 8-bit LFSR pseudo-random bit stream. It collects the serial `out` bit, sampled whenever that stage is enabled, into WIDTH-bit words. Completed words are buffered in a small FIFO and presented on a valid/ready output port, so the words can feed a register file or memory writer. Words that arrive while the FIFO is full are dropped and counted.

## Interface
- `WIDTH`, default 8: word width in bits, ≥2.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset is asynchronous and active-low. Asserting it (low) clears all state immediately; state is held while it is low.
- `bit_in` in 1: serial bit from the LFSR stage output.
- `bit_valid` in 1: `bit_in` is sampled this cycle (tie to the LFSR enable).
- `clear` in 1: synchronous flush of the partial word, FIFO, overflow flag and drop counter.
- `out_data` out WIDTH: FIFO head word; forced to 0 when `out_valid`=0.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head word this cycle.
- `level` out $clog2(DEPTH)+1: number of FIFO entries, 0..DEPTH.
- `overflow` out 1: sticky; set when any word has been dropped.
- `drop_count` out 8: number of dropped words, saturating at 255.

## Operation
- Reset values: `out_data`=0, `out_valid`=0, `level`=0, `overflow`=0, `drop_count`=0. The internal bit counter, shift register, and read/write pointers are all 0.
- Packing:
  - When `bit_valid`=1, `sr <= {sr[WIDTH-2:0], bit_in}` and `bitcnt` increments.
  - Bits are MSB-first: the first bit received lands in bit WIDTH-1 of the word.
  - On the cycle where `bitcnt`==WIDTH-1 and `bit_valid`=1, the word `{sr[WIDTH-2:0], bit_in}` is completed. `bitcnt` wraps to 0 on that same edge.
  - Idle cycles (`bit_valid`=0) hold the partial word indefinitely.
- Pop: occurs when `out_valid`=1 and `out_ready`=1. The head advances on that edge.
- Push: a completed word is written on that edge if `level`<DEPTH, or if `level`==DEPTH and a pop occurs in the same cycle (full plus simultaneous pop means no drop).
- Drop: a completed word with `level`==DEPTH and no pop is discarded. On that edge `overflow`←1 and `drop_count`←min(`drop_count`+1, 255).
- Level update:
  - push only: +1
  - pop only: −1
  - both push and pop: unchanged
- FIFO state: the two pointers wrap modulo DEPTH. `level` is the sole full/empty indicator.
- Clear: priority is `rst` > `clear` > normal operation.
  - `clear`=1 empties the FIFO, zeroes `bitcnt` and `sr`, and clears `overflow` and `drop_count`.
  - While `clear`=1, any `bit_valid` and any pop in that cycle are ignored.
- Words leave the FIFO in strict arrival order.

## Timing
- Write latency: the word completed at rising edge N is visible on `out_data` with `out_valid`=1 in the cycle after edge N, if the FIFO was empty.
- `out_valid` and `out_data` are registered state or a direct FIFO read. There is no combinational path from `out_ready` to `out_valid` or `out_data`.
- Throughput: one pop per cycle. The push rate is at most one word per WIDTH `bit_valid` cycles.
- Output stability: `out_data` must remain stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-word:
  - `rst` low discards the partial bits asynchronously.
  - After `rst` rises, the next WIDTH valid bits form a fresh word.
  - `rst` must be released synchronously to `clk` by the top level.

## Test plan
- Reset, `out_ready`=1, feed bits 1,0,1,1,0,0,1,0 on consecutive cycles → `out_data`=0xB2 with `out_valid`=1 for exactly one cycle, starting the cycle after the 8th bit edge; `level` returns to 0.
- Same 8 bits with 3 idle cycles inserted after bit 4 → identical word 0xB2, delayed by 3 cycles; no spurious word.
- `out_ready`=0, push words 0x01,0x02,0x03,0x04 → `level`=4. Push 0xFF → dropped, `overflow`=1, `drop_count`=1. Then assert `out_ready`=1 → drains 0x01,0x02,0x03,0x04 in that order, then `out_valid`=0.
- FIFO full, complete a word in the same cycle as a pop → no drop, `level` stays 4, the new word appears last in the drain order.
- Feed 5 bits, pull `rst` low mid-cycle → all outputs 0 immediately. Release `rst`, feed 8 bits of 0xA5 → `out_data`=0xA5.
- Hold `out_ready`=0 and complete 300 words → `level`=4, `drop_count`=255 (saturated), `overflow`=1. Pulse `clear` together with `bit_valid` → next cycle `level`=0, `overflow`=0, `drop_count`=0, `out_valid`=0, partial word empty.

Source files
------------

// File: rtl/lfsr_byte_packer.sv
// Packs the serial LFSR bit stream MSB-first into WIDTH-bit words and queues
// them in a small FIFO behind a valid/ready port; words arriving while full are dropped and counted.
module lfsr_byte_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [WIDTH-1:0] word_c;
    logic             done_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;

    // Word completion and FIFO handshake decode; a pop frees the slot for a same-cycle push.
    always_comb begin
        word_c = {sr, bit_in};
        done_c = bit_valid && (bitcnt == CW'(WIDTH - 1));
        pop_c  = out_valid && out_ready;
        push_c = done_c && ((level < LW'(DEPTH)) || pop_c);
        drop_c = done_c && !push_c;
    end

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr         <= '0;
            bitcnt     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            sr         <= '0;
            bitcnt     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (bit_valid) begin
                sr     <= word_c[WIDTH-2:0];
                bitcnt <= done_c ? '0 : bitcnt + CW'(1);
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_c && !pop_c) begin
                level <= level + LW'(1);
            end else if (pop_c && !push_c) begin
                level <= level - LW'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    // Storage array carries no reset; level alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push_c && !clear) begin
            mem[wr_ptr] <= word_c;
        end
    end

endmodule

// File: tb/tb_lfsr_byte_packer.sv
// Directed bench for lfsr_byte_packer: packing, idle gaps, overflow/drop, full+pop,
// asynchronous reset mid-word, drop counter saturation and clear.
module tb_lfsr_byte_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lfsr_byte_packer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one word MSB-first on consecutive cycles, then one idle cycle.
    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = w[7-i];
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Pops n words (first word in bits 31:24) and expects the FIFO empty afterwards.
    task automatic drain(input logic [31:0] words, input int n, input string tag);
        logic [7:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp = words[31-8*i -: 8];
            total++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                bad++;
                $display("FAIL %s_word%0d: got valid=%0b data=%02h want valid=1 data=%02h",
                         tag, i, out_valid, out_data, exp);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            bad++;
            $display("FAIL %s_empty: got valid=%0b level=%0d want valid=0 level=0",
                     tag, out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_out: got valid=%0b data=%02h want 0/00", out_valid, out_data);
        end
        total++;
        if (level !== 3'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_status: got level=%0d ovf=%0b drops=%0d want 0/0/0",
                     level, overflow, drop_count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // 0xB2 fed as 1,0,1,1,0,0,1,0 with 'gap' idle cycles after the 4th bit.
    task automatic test_packing(input int gap, input string tag);
        logic [7:0] w;
        logic [7:0] data;
        int first;
        int nvalid;
        int bi;
        w = 8'hB2; data = 8'h00; first = -1; nvalid = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 14 + gap; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                nvalid++;
                if (first < 0) begin
                    first = c;
                    data  = out_data;
                end
            end
            if (c < 4) bi = c;
            else if (c < 4 + gap) bi = -1;
            else if (c < 8 + gap) bi = c - gap;
            else bi = -1;
            bit_valid = (bi >= 0);
            bit_in    = (bi >= 0) ? w[7-bi] : 1'b0;
        end
        total++;
        if (first != 8 + gap) begin
            bad++;
            $display("FAIL %s_latency: got first valid cycle %0d want %0d", tag, first, 8 + gap);
        end
        total++;
        if (nvalid != 1) begin
            bad++;
            $display("FAIL %s_count: got %0d valid cycles want 1", tag, nvalid);
        end
        total++;
        if (data !== 8'hB2) begin
            bad++;
            $display("FAIL %s_data: got %02h want b2", tag, data);
        end
        total++;
        if (level !== 3'd0) begin
            bad++;
            $display("FAIL %s_level: got %0d want 0", tag, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        push_word(8'h04);
        total++;
        if (level !== 3'd4 || overflow !== 1'b0 || out_data !== 8'h01) begin
            bad++;
            $display("FAIL ovf_full: got level=%0d ovf=%0b data=%02h want 4/0/01",
                     level, overflow, out_data);
        end
        push_word(8'hFF);
        total++;
        if (level !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd1) begin
            bad++;
            $display("FAIL ovf_drop: got level=%0d ovf=%0b drops=%0d want 4/1/1",
                     level, overflow, drop_count);
        end
        drain(32'h01020304, 4, "ovf");
    endtask

    task automatic test_full_pop();
        logic [7:0] w;
        do_reset();
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        w = 8'h55;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = w[7-i];
            if (i == 7) out_ready = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        total++;
        if (level !== 3'd4 || drop_count !== 8'd0 || overflow !== 1'b0 || out_data !== 8'h22) begin
            bad++;
            $display("FAIL fullpop_state: got level=%0d drops=%0d ovf=%0b data=%02h want 4/0/0/22",
                     level, drop_count, overflow, out_data);
        end
        drain(32'h33445500, 3, "fullpop");
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        push_word(8'h3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_async: got valid=%0b data=%02h level=%0d want 0/00/0",
                     out_valid, out_data, level);
        end
        @(negedge clk);
        rst = 1'b1;
        push_word(8'hA5);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 3'd1) begin
            bad++;
            $display("FAIL rstmid_word: got valid=%0b data=%02h level=%0d want 1/a5/1",
                     out_valid, out_data, level);
        end
    endtask

    task automatic test_saturate_clear();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            push_word(8'(k));
        end
        total++;
        if (level !== 3'd4 || drop_count !== 8'd255 || overflow !== 1'b1 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL sat_state: got level=%0d drops=%0d ovf=%0b data=%02h want 4/255/1/00",
                     level, drop_count, overflow, out_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = 1'b1;
        end
        @(negedge clk);
        clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
        total++;
        if (level !== 3'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            bad++;
            $display("FAIL clear_status: got level=%0d ovf=%0b drops=%0d want 0/0/0",
                     level, overflow, drop_count);
        end
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL clear_out: got valid=%0b data=%02h want 0/00", out_valid, out_data);
        end
        push_word(8'h5A);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || level !== 3'd1) begin
            bad++;
            $display("FAIL clear_partial: got valid=%0b data=%02h level=%0d want 1/5a/1",
                     out_valid, out_data, level);
        end
    endtask

    initial begin
        test_reset();
        test_packing(0, "pack");
        test_packing(3, "gap");
        test_overflow();
        test_full_pop();
        test_reset_mid_word();
        test_saturate_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
